// File: rtl/rr_protocol_pkg.sv
// Shared definitions for the round-robin memory server: FSM states and
// request-word field positions.
package rr_protocol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    WAIT,
    RESPOND
  } state_e;

  localparam int REQ_WRITE_BIT = 32;
  localparam int REQ_OFF_HI    = 31;
  localparam int REQ_OFF_LO    = 16;
  localparam int REQ_DATA_HI   = 15;
  localparam int REQ_DATA_LO   = 0;

endpackage

// File: rtl/rr_mem_server_if.sv
// Arbiter-facing request/ready handshake between the arbiter (master) and
// the memory server (slave).
interface rr_mem_server_if #(
  parameter int req_data_width    = 33,
  parameter int handle_width      = 8,
  parameter int server_data_width = 16
);

  logic                         arbiter_req;
  logic [req_data_width-1:0]    arbiter_req_data;
  logic [handle_width-1:0]      arbiter_req_handle;
  logic [server_data_width-1:0] server_data;
  logic                         server_ready;

  modport master (
    output arbiter_req, arbiter_req_data, arbiter_req_handle,
    input  server_data, server_ready
  );

  modport slave (
    input  arbiter_req, arbiter_req_data, arbiter_req_handle,
    output server_data, server_ready
  );

endinterface

// File: rtl/rr_region_table.sv
// Per-handle region table (base/length) with synchronous write and
// combinational read; out-of-range handles read as disabled.
module rr_region_table #(
  parameter int n_handles    = 16,
  parameter int handle_width = 8,
  parameter int addr_width   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [handle_width-1:0] cfg_handle,
  input  logic [addr_width-1:0]   cfg_base,
  input  logic [addr_width-1:0]   cfg_len,
  input  logic [handle_width-1:0] rd_handle,
  output logic [addr_width-1:0]   rd_base,
  output logic [addr_width-1:0]   rd_len
);

  localparam int idx_width = (n_handles > 1) ? $clog2(n_handles) : 1;

  logic [addr_width-1:0] base_q [n_handles];
  logic [addr_width-1:0] base_d [n_handles];
  logic [addr_width-1:0] len_q  [n_handles];
  logic [addr_width-1:0] len_d  [n_handles];
  logic                  cfg_hit;
  logic                  rd_hit;
  logic [idx_width-1:0]  cfg_idx;
  logic [idx_width-1:0]  rd_idx;

  assign cfg_hit = int'(cfg_handle) < n_handles;
  assign rd_hit  = int'(rd_handle) < n_handles;
  assign cfg_idx = cfg_handle[idx_width-1:0];
  assign rd_idx  = rd_handle[idx_width-1:0];

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    if (cfg_we && cfg_hit) begin
      base_d[cfg_idx] = cfg_base;
      len_d[cfg_idx]  = cfg_len;
    end
  end

  // Only lengths need clearing: a zero length disables the handle regardless of base.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    if (reset) begin
      for (int i = 0; i < n_handles; i++) len_q[i] <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  assign rd_base = rd_hit ? base_q[rd_idx] : '0;
  assign rd_len  = rd_hit ? len_q[rd_idx]  : '0;

endmodule

// File: rtl/rr_mem_server.sv
// Responder for the arbiter request/ready protocol: maps a handle-relative
// offset into a wrapped SRAM region, performs the access, returns one strobe.
module rr_mem_server
  import rr_protocol_pkg::*;
#(
  parameter int req_data_width    = 33,
  parameter int handle_width      = 8,
  parameter int server_data_width = 16,
  parameter int addr_width        = 16,
  parameter int n_handles         = 16,
  parameter int mem_latency       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  rr_mem_server_if.slave               arb,
  input  logic                         cfg_we,
  input  logic [handle_width-1:0]      cfg_handle,
  input  logic [addr_width-1:0]        cfg_base,
  input  logic [addr_width-1:0]        cfg_len,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [addr_width-1:0]        mem_addr,
  output logic [server_data_width-1:0] mem_wdata,
  input  logic [server_data_width-1:0] mem_rdata,
  output logic                         busy,
  output logic                         protocol_err
);

  localparam int cnt_width = (mem_latency > 1) ? $clog2(mem_latency + 1) : 1;

  state_e                         state_q, state_d;
  logic [req_data_width-1:0]      req_q, req_d;
  logic [handle_width-1:0]        handle_q, handle_d;
  logic [addr_width-1:0]          addr_q, addr_d;
  logic                           en_q, en_d;
  logic                           wr_q, wr_d;
  logic [cnt_width-1:0]           cnt_q, cnt_d;
  logic                           mem_en_q, mem_en_d;
  logic                           mem_we_q, mem_we_d;
  logic [addr_width-1:0]          mem_addr_q, mem_addr_d;
  logic [server_data_width-1:0]   mem_wdata_q, mem_wdata_d;
  logic                           server_ready_q, server_ready_d;
  logic [server_data_width-1:0]   server_data_q, server_data_d;
  logic                           busy_q, busy_d;
  logic                           err_q, err_d;

  logic [addr_width-1:0]          tbl_base;
  logic [addr_width-1:0]          tbl_len;
  logic [addr_width-1:0]          offset;
  logic [addr_width-1:0]          eff_off;
  logic [addr_width-1:0]          lookup_addr;

  rr_region_table #(
    .n_handles    (n_handles),
    .handle_width (handle_width),
    .addr_width   (addr_width)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_handle (cfg_handle),
    .cfg_base   (cfg_base),
    .cfg_len    (cfg_len),
    .rd_handle  (handle_q),
    .rd_base    (tbl_base),
    .rd_len     (tbl_len)
  );

  // A single conditional subtraction; offsets beyond twice the length are not reduced further.
  assign offset      = req_q[REQ_OFF_HI:REQ_OFF_LO];
  assign eff_off     = (offset >= tbl_len) ? offset - tbl_len : offset;
  assign lookup_addr = tbl_base + eff_off;

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    handle_d       = handle_q;
    addr_d         = addr_q;
    en_d           = en_q;
    wr_d           = wr_q;
    cnt_d          = cnt_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    server_ready_d = 1'b0;
    server_data_d  = server_data_q;
    err_d          = err_q;

    case (state_q)
      IDLE: begin
        if (arb.arbiter_req) begin
          req_d    = arb.arbiter_req_data;
          handle_d = arb.arbiter_req_handle;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        addr_d  = lookup_addr;
        en_d    = (tbl_len != '0);
        wr_d    = req_q[REQ_WRITE_BIT];
        state_d = ISSUE;
      end
      ISSUE: begin
        mem_en_d = en_q;
        mem_we_d = en_q && wr_q;
        if (en_q) begin
          mem_addr_d  = addr_q;
          mem_wdata_d = req_q[REQ_DATA_HI:REQ_DATA_LO];
        end
        cnt_d   = cnt_width'(mem_latency - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESPOND;
        else             cnt_d   = cnt_q - cnt_width'(1);
      end
      RESPOND: begin
        server_ready_d = 1'b1;
        server_data_d  = (en_q && !wr_q) ? mem_rdata : '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request outside IDLE is dropped but remembered until reset.
    if (arb.arbiter_req && state_q != IDLE) err_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      req_q          <= '0;
      handle_q       <= '0;
      addr_q         <= '0;
      en_q           <= 1'b0;
      wr_q           <= 1'b0;
      cnt_q          <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      server_ready_q <= 1'b0;
      server_data_q  <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      handle_q       <= handle_d;
      addr_q         <= addr_d;
      en_q           <= en_d;
      wr_q           <= wr_d;
      cnt_q          <= cnt_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      server_ready_q <= server_ready_d;
      server_data_q  <= server_data_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign arb.server_ready = server_ready_q;
  assign arb.server_data  = server_data_q;
  assign mem_en           = mem_en_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign busy             = busy_q;
  assign protocol_err     = err_q;

endmodule

// File: tb/tb_rr_mem_server.sv
// Directed testbench for rr_mem_server with a behavioural two-stage SRAM
// model; expected values are hand-computed per request.
module tb_rr_mem_server;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [7:0]  cfg_handle;
  logic [15:0] cfg_base;
  logic [15:0] cfg_len;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        protocol_err;

  int cmp_count  = 0;
  int fail_count = 0;

  int          obs_ready_edge;
  int          obs_ready_cnt;
  int          obs_en_cnt;
  int          obs_busy_cnt;
  logic [15:0] obs_addr;
  logic [15:0] obs_wdata;
  logic        obs_we;
  logic [15:0] obs_data;

  always #5 clk = ~clk;

  rr_mem_server_if arb_if ();

  rr_mem_server dut (
    .clk          (clk),
    .reset        (reset),
    .arb          (arb_if),
    .cfg_we       (cfg_we),
    .cfg_handle   (cfg_handle),
    .cfg_base     (cfg_base),
    .cfg_len      (cfg_len),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  // SRAM with two-cycle read latency: address sampled with mem_en, data two edges later.
  logic [15:0] sram [0:65535];
  logic [15:0] sram_p1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      sram_p1 <= sram[mem_addr];
    end
    mem_rdata <= sram_p1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic configRegion(input logic [7:0] h, input logic [15:0] base, input logic [15:0] len);
    cfg_we     = 1'b1;
    cfg_handle = h;
    cfg_base   = base;
    cfg_len    = len;
    @(posedge clk); #1;
    cfg_we     = 1'b0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] off, input logic [15:0] wd,
                               input logic [7:0] h, input bit inject, input bit race,
                               input bit rst_mid);
    arb_if.arbiter_req        = 1'b1;
    arb_if.arbiter_req_data   = {wr, off, wd};
    arb_if.arbiter_req_handle = h;
    @(posedge clk); #1;
    arb_if.arbiter_req = 1'b0;
    obs_ready_edge = -1;
    obs_ready_cnt  = 0;
    obs_en_cnt     = 0;
    obs_busy_cnt   = 0;
    obs_addr       = '0;
    obs_wdata      = '0;
    obs_we         = 1'b0;
    if (race) begin
      cfg_we     = 1'b1;
      cfg_handle = 8'd3;
      cfg_base   = 16'h2000;
      cfg_len    = 16'h0100;
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) cfg_we = 1'b0;
      if (mem_en) begin
        obs_en_cnt++;
        obs_addr  = mem_addr;
        obs_we    = mem_we;
        obs_wdata = mem_wdata;
      end
      if (arb_if.server_ready) begin
        obs_ready_cnt++;
        if (obs_ready_edge < 0) obs_ready_edge = k;
      end
      if (busy) obs_busy_cnt++;
      if (inject && k == 2) begin
        arb_if.arbiter_req        = 1'b1;
        arb_if.arbiter_req_data   = {1'b1, 16'h0030, 16'hDEAD};
        arb_if.arbiter_req_handle = 8'd3;
      end
      if (k == 3) arb_if.arbiter_req = 1'b0;
      if (rst_mid && k == 2) reset = 1'b1;
      if (rst_mid && k == 3) reset = 1'b0;
    end
    obs_data = arb_if.server_data;
  endtask

  initial begin
    reset                     = 1'b1;
    cfg_we                    = 1'b0;
    cfg_handle                = '0;
    cfg_base                  = '0;
    cfg_len                   = '0;
    arb_if.arbiter_req        = 1'b0;
    arb_if.arbiter_req_data   = '0;
    arb_if.arbiter_req_handle = '0;
    sram[16'h1010] = 16'hBEEF;
    sram[16'h1150] = 16'h5A5A;
    sram[16'h1000] = 16'h0F0F;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", arb_if.server_ready, 0);
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_err",   protocol_err, 0);
    checkOutput("rst_en",    mem_en, 0);
    checkOutput("rst_we",    mem_we, 0);
    checkOutput("rst_data",  arb_if.server_data, 0);
    checkOutput("rst_addr",  mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    reset = 1'b0;

    configRegion(8'd3, 16'h1000, 16'h0100);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 8'd3, 0, 0, 0);
    checkOutput("rd_en_cnt",  obs_en_cnt, 1);
    checkOutput("rd_addr",    obs_addr, 16'h1010);
    checkOutput("rd_we",      obs_we, 0);
    checkOutput("rd_latency", obs_ready_edge, 5);
    checkOutput("rd_ready_n", obs_ready_cnt, 1);
    checkOutput("rd_busy_n",  obs_busy_cnt, 4);
    checkOutput("rd_data",    obs_data, 16'hBEEF);

    applyStimulus(1'b1, 16'h0105, 16'h1234, 8'd3, 0, 0, 0);
    checkOutput("wr_en_cnt",  obs_en_cnt, 1);
    checkOutput("wr_we",      obs_we, 1);
    checkOutput("wr_addr",    obs_addr, 16'h1005);
    checkOutput("wr_wdata",   obs_wdata, 16'h1234);
    checkOutput("wr_latency", obs_ready_edge, 5);
    checkOutput("wr_data",    obs_data, 16'h0000);

    applyStimulus(1'b0, 16'h0005, 16'h0000, 8'd3, 0, 0, 0);
    checkOutput("rdback_addr", obs_addr, 16'h1005);
    checkOutput("rdback_data", obs_data, 16'h1234);

    applyStimulus(1'b0, 16'h0250, 16'h0000, 8'd3, 0, 0, 0);
    checkOutput("far_off_addr", obs_addr, 16'h1150);
    checkOutput("far_off_data", obs_data, 16'h5A5A);

    applyStimulus(1'b0, 16'h0100, 16'h0000, 8'd3, 0, 0, 0);
    checkOutput("off_eq_len_addr", obs_addr, 16'h1000);
    checkOutput("off_eq_len_data", obs_data, 16'h0F0F);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 8'd20, 0, 0, 0);
    checkOutput("h20_en_cnt",  obs_en_cnt, 0);
    checkOutput("h20_latency", obs_ready_edge, 5);
    checkOutput("h20_data",    obs_data, 16'h0000);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 8'd5, 0, 0, 0);
    checkOutput("len0_en_cnt",  obs_en_cnt, 0);
    checkOutput("len0_latency", obs_ready_edge, 5);
    checkOutput("len0_data",    obs_data, 16'h0000);

    configRegion(8'd16, 16'h3000, 16'h0010);
    applyStimulus(1'b0, 16'h0001, 16'h0000, 8'd16, 0, 0, 0);
    checkOutput("cfg16_en_cnt", obs_en_cnt, 0);
    applyStimulus(1'b0, 16'h0001, 16'h0000, 8'd0, 0, 0, 0);
    checkOutput("cfg16_h0_en_cnt", obs_en_cnt, 0);
    checkOutput("no_err_yet", protocol_err, 0);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 8'd3, 1, 0, 0);
    checkOutput("viol_err",     protocol_err, 1);
    checkOutput("viol_ready_n", obs_ready_cnt, 1);
    checkOutput("viol_en_cnt",  obs_en_cnt, 1);
    checkOutput("viol_data",    obs_data, 16'hBEEF);

    applyStimulus(1'b0, 16'h0020, 16'h0000, 8'd3, 0, 1, 0);
    checkOutput("race_old_addr", obs_addr, 16'h1020);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 8'd3, 0, 0, 0);
    checkOutput("race_new_addr", obs_addr, 16'h2020);
    checkOutput("err_sticky",    protocol_err, 1);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 8'd3, 0, 0, 1);
    checkOutput("midrst_ready_n", obs_ready_cnt, 0);
    checkOutput("midrst_busy",    busy, 0);
    checkOutput("midrst_err",     protocol_err, 0);

    applyStimulus(1'b0, 16'h0010, 16'h0000, 8'd3, 0, 0, 0);
    checkOutput("postrst_en_cnt",  obs_en_cnt, 0);
    checkOutput("postrst_latency", obs_ready_edge, 5);
    checkOutput("postrst_data",    obs_data, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
